req_assert_monitor: RTL

Synthesisable, parametrised request-assertion monitor for N request lines. While the design is in its request state, at least one request (or exactly one, by mode) must be asserted within a configurable window. Violations are time-stamped with a free-running cycle counter and reported after a fixed delay. Counters and sticky flags are kept for status readout. The block sits beside the arbiter/request logic as a hardware checker that also survives into silicon.

---
 rtl/req_assert_pkg.sv | 16 +
 rtl/req_assert_delay_line.sv | 45 ++++
 rtl/req_assert_monitor.sv | 98 +++++++++
 3 files changed

// File: rtl/req_assert_pkg.sv
// Shared types and helpers for the request-assertion monitor.
package req_assert_pkg;

  typedef enum logic {
    MODE_ANY    = 1'b0,
    MODE_ONEHOT = 1'b1
  } req_mode_e;

  localparam int WCNT_W = 8;

  // Saturating increment on a 32-bit carrier; callers truncate to their width.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max);
    return (v >= max) ? max : v + 32'd1;
  endfunction

endpackage

// File: rtl/req_assert_delay_line.sv
// Fixed-depth shift register of violation reports {valid, timestamp, req snapshot}.
module req_assert_delay_line #(
  parameter int DEPTH = 5,
  parameter int TS_W  = 32,
  parameter int N_REQ = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_vld,
  input  logic [TS_W-1:0]  in_ts,
  input  logic [N_REQ-1:0] in_snap,
  output logic             out_vld,
  output logic [TS_W-1:0]  out_ts,
  output logic [N_REQ-1:0] out_snap
);

  logic [DEPTH-1:0]            vld_pipe;
  logic [DEPTH-1:0][TS_W-1:0]  ts_pipe;
  logic [DEPTH-1:0][N_REQ-1:0] snap_pipe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe  <= '0;
      ts_pipe   <= '0;
      snap_pipe <= '0;
    end else if (flush) begin
      vld_pipe  <= '0;
    end else begin
      vld_pipe[0]  <= in_vld;
      ts_pipe[0]   <= in_ts;
      snap_pipe[0] <= in_snap;
      for (int i = 1; i < DEPTH; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        ts_pipe[i]   <= ts_pipe[i-1];
        snap_pipe[i] <= snap_pipe[i-1];
      end
    end
  end

  assign out_vld  = vld_pipe[DEPTH-1];
  assign out_ts   = ts_pipe[DEPTH-1];
  assign out_snap = snap_pipe[DEPTH-1];

endmodule

// File: rtl/req_assert_monitor.sv
// Request-assertion checker: window counter, free-running timestamp, delayed
// violation reports and sticky/saturating status for readout.
module req_assert_monitor
  import req_assert_pkg::*;
#(
  parameter int N_REQ        = 2,
  parameter int WINDOW       = 1,
  parameter int REPORT_DELAY = 5,
  parameter int TS_W         = 32,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             state_req,
  input  logic [N_REQ-1:0] req,
  input  logic             mode,
  input  logic             clr,
  output logic             fail_pulse,
  output logic             fail_sticky,
  output logic [CNT_W-1:0] fail_count,
  output logic [TS_W-1:0]  fail_time,
  output logic [N_REQ-1:0] fail_req,
  output logic [TS_W-1:0]  cycle
);

  req_mode_e          mode_e;
  logic               met;
  logic               viol;
  logic [WCNT_W-1:0]  wcnt;
  logic [WCNT_W-1:0]  wcnt_nxt;
  logic               rpt_vld;
  logic [TS_W-1:0]    rpt_ts;
  logic [N_REQ-1:0]   rpt_snap;

  assign mode_e = req_mode_e'(mode);

  always_comb begin
    met = |req;
    if (mode_e == MODE_ONEHOT)
      met = (req != '0) && ((req & (req - N_REQ'(1))) == '0);
  end

  // wcnt holds the number of unmet samples already seen; this sample is the
  // WINDOW-th one when wcnt sits at WINDOW-1. clr suppresses capture outright.
  assign viol = en && state_req && !met && !clr && (wcnt == WCNT_W'(WINDOW - 1));

  always_comb begin
    wcnt_nxt = wcnt + WCNT_W'(1);
    if (clr || !en || !state_req || met || viol)
      wcnt_nxt = '0;
  end

  req_assert_delay_line #(
    .DEPTH (REPORT_DELAY),
    .TS_W  (TS_W),
    .N_REQ (N_REQ)
  ) u_dly (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (clr),
    .in_vld   (viol),
    .in_ts    (cycle),
    .in_snap  (req),
    .out_vld  (rpt_vld),
    .out_ts   (rpt_ts),
    .out_snap (rpt_snap)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle       <= '0;
      wcnt        <= '0;
      fail_pulse  <= 1'b0;
      fail_sticky <= 1'b0;
      fail_count  <= '0;
      fail_time   <= '0;
      fail_req    <= '0;
    end else begin
      cycle      <= cycle + TS_W'(1);
      wcnt       <= wcnt_nxt;
      fail_pulse <= 1'b0;
      if (clr) begin
        fail_sticky <= 1'b0;
        fail_count  <= '0;
        fail_time   <= '0;
        fail_req    <= '0;
      end else if (rpt_vld) begin
        fail_pulse  <= 1'b1;
        fail_sticky <= 1'b1;
        fail_count  <= CNT_W'(sat_inc(32'(fail_count), 32'({CNT_W{1'b1}})));
        fail_time   <= rpt_ts;
        fail_req    <= rpt_snap;
      end
    end
  end

endmodule
